// File: rtl/tetris_board_ctrl.sv
// tetris_board_ctrl: merges landed pieces into the playfield, clears full rows and flags overflow.
// Rows are stored top-down (row 0 at the top), with rd_data bit c holding column c.
module tetris_board_ctrl #(
    parameter int ROWS   = 24,
    parameter int COLS   = 10,
    parameter int HIDDEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lock_req,
    input  logic [15:0]     lock_shape,
    input  logic [5:0]      lock_x,
    input  logic [5:0]      lock_y,
    input  logic            clr,
    input  logic [4:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            busy,
    output logic            lock_done,
    output logic [2:0]      lines_cleared,
    output logic            oob,
    output logic            overflow
);
    localparam int RW = $clog2(ROWS);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MERGE = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state;
    logic [COLS-1:0] board [ROWS];
    logic [15:0]     sh;
    logic [5:0]      lx;
    logic [5:0]      ly;
    logic [1:0]      mrow;
    logic [RW-1:0]   idx;
    logic [3:0]      sh_row;
    logic [6:0]      br;
    logic            row_ok;
    logic [COLS-1:0] mask;
    logic            drop;
    logic            hid_any;
    logic            row_full;
    logic            above_full;

    assign rd_data   = (rd_row < 5'(ROWS)) ? board[rd_row] : '0;
    assign busy      = state != S_IDLE;
    assign lock_done = state == S_DONE;
    assign row_full   = &board[idx];
    assign above_full = (idx != '0) && (&board[idx - 1'b1]);

    // Cells of the current shape row that land inside the board, plus a flag for any that fall off.
    always_comb begin
        sh_row = 4'(sh >> {mrow, 2'b00});
        br     = {ly[5], ly} + 7'(mrow) + 7'(HIDDEN);
        row_ok = !br[6] && (br < 7'(ROWS));
        mask   = '0;
        drop   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (sh_row[c] && row_ok && (({1'b0, lx} + 7'(c)) < 7'(COLS)))
                mask = mask | (COLS'(1) << ({1'b0, lx} + 7'(c)));
            else if (sh_row[c])
                drop = 1'b1;
        end
        hid_any = 1'b0;
        for (int k = 0; k < HIDDEN; k++)
            hid_any = hid_any | (|board[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            for (int k = 0; k < ROWS; k++)
                board[k] <= '0;
            sh            <= '0;
            lx            <= '0;
            ly            <= '0;
            mrow          <= '0;
            idx           <= '0;
            lines_cleared <= '0;
            oob           <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr) begin
                        for (int k = 0; k < ROWS; k++)
                            board[k] <= '0;
                        overflow <= 1'b0;
                    end else if (lock_req) begin
                        sh            <= lock_shape;
                        lx            <= lock_x;
                        ly            <= lock_y;
                        lines_cleared <= '0;
                        oob           <= 1'b0;
                        overflow      <= 1'b0;
                        mrow          <= '0;
                        state         <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    if (row_ok)
                        board[br[RW-1:0]] <= board[br[RW-1:0]] | mask;
                    oob  <= oob | drop;
                    mrow <= mrow + 1'b1;
                    if (mrow == 2'd3) begin
                        idx   <= RW'(ROWS - 1);
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (row_full)
                        state <= S_SHIFT;
                    else if (idx == '0)
                        state <= S_DONE;
                    else
                        idx <= idx - 1'b1;
                end
                S_SHIFT: begin
                    for (int k = 1; k < ROWS; k++)
                        if (RW'(k) <= idx)
                            board[k] <= board[k-1];
                    board[0] <= '0;
                    if (lines_cleared != 3'd7)
                        lines_cleared <= lines_cleared + 1'b1;
                    // The row dropping into idx is tested here, so a full one is removed without a rescan cycle.
                    state <= above_full ? S_SHIFT : (idx == '0) ? S_DONE : S_SCAN;
                    if (!above_full && idx != '0)
                        idx <= idx - 1'b1;
                end
                S_DONE: begin
                    overflow <= hid_any;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_board_ctrl.sv
// tb_tetris_board_ctrl: table-driven lock sequences plus hand-written corner cases for tetris_board_ctrl.
module tb_tetris_board_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lock_req = 1'b0;
    logic [15:0] lock_shape = '0;
    logic [5:0]  lock_x = '0;
    logic [5:0]  lock_y = '0;
    logic        clr = 1'b0;
    logic [4:0]  rd_row = '0;
    logic [9:0]  rd_data;
    logic        busy;
    logic        lock_done;
    logic [2:0]  lines_cleared;
    logic        oob;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    tetris_board_ctrl dut (
        .clk(clk), .rst(rst), .lock_req(lock_req), .lock_shape(lock_shape),
        .lock_x(lock_x), .lock_y(lock_y), .clr(clr), .rd_row(rd_row),
        .rd_data(rd_data), .busy(busy), .lock_done(lock_done),
        .lines_cleared(lines_cleared), .oob(oob), .overflow(overflow)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic        clr_first;
        logic [15:0] shape;
        logic [5:0]  x;
        logic [5:0]  y;
        int          ra;
        logic [9:0]  da;
        int          rb;
        logic [9:0]  db;
        logic [2:0]  lines;
        logic        oob;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input int r, output logic [9:0] d);
        rd_row = 5'(r);
        #1;
        d = rd_data;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic do_lock(input logic [15:0] s, input logic [5:0] x, input logic [5:0] y, output int lat);
        @(negedge clk);
        lock_req = 1'b1;
        lock_shape = s;
        lock_x = x;
        lock_y = y;
        @(posedge clk);
        #1;
        lock_req = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (lock_done) begin
                lat = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("busy_back_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [9:0] d;
        int lat;
        tbl[0] = '{1'b0, 16'h0033, 6'd4, 6'd18, 22, 10'h030, 23, 10'h030, 3'd0, 1'b0, 1'b0, 28};
        tbl[1] = '{1'b1, 16'h000F, 6'd0, 6'd19, 23, 10'h00F, 22, 10'h000, 3'd0, 1'b0, 1'b0, 28};
        tbl[2] = '{1'b0, 16'h000F, 6'd4, 6'd19, 23, 10'h0FF, 22, 10'h000, 3'd0, 1'b0, 1'b0, 28};
        tbl[3] = '{1'b0, 16'h0033, 6'd8, 6'd18, 23, 10'h300, 22, 10'h000, 3'd1, 1'b0, 1'b0, 29};
        tbl[4] = '{1'b0, 16'h000F, 6'd8, 6'd19, 23, 10'h300, 22, 10'h000, 3'd0, 1'b1, 1'b0, 28};
        tbl[5] = '{1'b0, 16'h0033, 6'd0, 6'h3C,  0, 10'h003,  1, 10'h003, 3'd0, 1'b0, 1'b1, 28};
        tbl[6] = '{1'b1, 16'h00FF, 6'd0, 6'd18, 22, 10'h00F, 23, 10'h00F, 3'd0, 1'b0, 1'b0, 28};
        tbl[7] = '{1'b0, 16'h00FF, 6'd4, 6'd18, 22, 10'h0FF, 23, 10'h0FF, 3'd0, 1'b0, 1'b0, 28};
        tbl[8] = '{1'b0, 16'h0033, 6'd8, 6'd18, 22, 10'h000, 23, 10'h000, 3'd2, 1'b0, 1'b0, 30};

        #5;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(lock_done), 32'd0);
        chk("rst_lines", 32'(lines_cleared), 32'd0);
        chk("rst_oob", 32'(oob), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        for (int r = 0; r < 24; r++) begin
            rd(r, d);
            chk($sformatf("rst_row%0d", r), 32'(d), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].clr_first)
                do_clr();
            do_lock(tbl[i].shape, tbl[i].x, tbl[i].y, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d_lines", i), 32'(lines_cleared), 32'(tbl[i].lines));
            chk($sformatf("v%0d_oob", i), 32'(oob), 32'(tbl[i].oob));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            rd(tbl[i].ra, d);
            chk($sformatf("v%0d_row%0d", i, tbl[i].ra), 32'(d), 32'(tbl[i].da));
            rd(tbl[i].rb, d);
            chk($sformatf("v%0d_row%0d", i, tbl[i].rb), 32'(d), 32'(tbl[i].db));
            if (i == 5) begin
                do_clr();
                chk("clr_ovf", 32'(overflow), 32'd0);
                for (int r = 0; r < 24; r++) begin
                    rd(r, d);
                    chk($sformatf("clr_row%0d", r), 32'(d), 32'd0);
                end
            end
        end

        // lock_req held while busy must not start a second merge.
        do_clr();
        @(negedge clk);
        lock_req = 1'b1;
        lock_shape = 16'h000F;
        lock_x = 6'd0;
        lock_y = 6'd19;
        @(posedge clk);
        #1;
        lock_shape = 16'h000F;
        lock_x = 6'd4;
        for (int n = 0; n < 10; n++)
            @(posedge clk);
        #1;
        lock_req = 1'b0;
        lat = -1;
        for (int n = 11; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (lock_done) begin
                lat = n;
                break;
            end
        end
        chk("busy_req_latency", 32'(lat), 32'd28);
        for (int n = 0; n < 5; n++)
            @(posedge clk);
        #1;
        chk("busy_req_idle", 32'(busy), 32'd0);
        rd(23, d);
        chk("busy_req_row23", 32'(d), 32'h00F);

        // clr and lock_req together: wipe wins.
        @(negedge clk);
        clr = 1'b1;
        lock_req = 1'b1;
        lock_shape = 16'h0033;
        lock_x = 6'd0;
        lock_y = 6'd18;
        @(posedge clk);
        #1;
        clr = 1'b0;
        lock_req = 1'b0;
        chk("clr_req_busy", 32'(busy), 32'd0);
        rd(23, d);
        chk("clr_req_row23", 32'(d), 32'd0);
        rd(22, d);
        chk("clr_req_row22", 32'(d), 32'd0);
        for (int n = 0; n < 30; n++)
            @(posedge clk);
        #1;
        chk("clr_req_idle", 32'(busy), 32'd0);
        rd(22, d);
        chk("clr_req_row22_late", 32'(d), 32'd0);

        // Reset in SCAN aborts immediately.
        @(negedge clk);
        lock_req = 1'b1;
        lock_shape = 16'h0033;
        lock_x = 6'd4;
        lock_y = 6'd18;
        @(posedge clk);
        #1;
        lock_req = 1'b0;
        for (int n = 0; n < 10; n++)
            @(posedge clk);
        #1;
        rd(23, d);
        chk("scan_row23_pre", 32'(d), 32'h030);
        rst = 1'b0;
        #1;
        chk("rst_scan_busy", 32'(busy), 32'd0);
        rd(23, d);
        chk("rst_scan_row23", 32'(d), 32'd0);
        rd(22, d);
        chk("rst_scan_row22", 32'(d), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        lat = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (lock_done || busy)
                lat = 1;
        end
        chk("rst_scan_quiet", 32'(lat), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
